// File: rtl/fft_pkg.sv
// Shared radix-8 twiddle definitions for the FFT/IFFT twiddle stages.
package fft_pkg;

   localparam logic [1:0] TW_0   = 2'd0;
   localparam logic [1:0] TW_45  = 2'd1;
   localparam logic [1:0] TW_90  = 2'd2;
   localparam logic [1:0] TW_135 = 2'd3;

   localparam int BLOCK_SIZE = 8;

   // DIF radix-2^3 order: only the upper half of a block is rotated, with a bit-reversed k.
   function automatic logic [1:0] tw8_index(input logic [2:0] p);
      return p[2] ? {p[0], p[1]} : TW_0;
   endfunction

endpackage

// File: rtl/rsqrt2_scale.sv
// Combinational shift-add 1/sqrt2 scaler (gain 181/256).
// Build option TWIDDLE8_CONJ_ROUND_EN: round-half-up before each arithmetic shift.
module rsqrt2_scale #(
   parameter int WIDTH = 12
) (
   input  logic signed [WIDTH-1:0] i_x,
   output logic signed [WIDTH-1:0] o_y
);

   localparam int WE = WIDTH + 1;

   logic signed [WE-1:0] w_x;
   logic signed [WE-1:0] w_t1;
   logic signed [WE-1:0] w_t2;
   logic signed [WE-1:0] w_y;

   function automatic logic signed [WE-1:0] asr(input logic signed [WE-1:0] v, input int sh);
      logic signed [WE-1:0] w_v;
      w_v = v;
`ifdef TWIDDLE8_CONJ_ROUND_EN
      w_v = v + $signed(WE'(1) << (sh - 1));
`endif
      return w_v >>> sh;
   endfunction

   // One guard bit keeps the rounding offset from wrapping near full scale.
   assign w_x  = {i_x[WIDTH-1], i_x};
   assign w_t1 = w_x - asr(w_x, 4);
   assign w_t2 = w_t1 + asr(w_t1, 2);
   assign w_y  = w_x - asr(w_t2, 2);
   assign o_y  = WIDTH'(w_y);

endmodule

// File: rtl/twiddle8_conj_stream.sv
// Streaming W8^-k rotation for the IFFT path; two-stage valid/ready pipeline.
// Build option TWIDDLE8_CONJ_ROUND_EN selects rounding in the 1/sqrt2 scaler.
module twiddle8_conj_stream
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH_IN  = 10,
   parameter int DATA_WIDTH_OUT = DATA_WIDTH_IN + 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             in_sync,
   input  logic signed [DATA_WIDTH_IN-1:0]  din_real,
   input  logic signed [DATA_WIDTH_IN-1:0]  din_imag,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             out_last,
   output logic signed [DATA_WIDTH_OUT-1:0] dout_real,
   output logic signed [DATA_WIDTH_OUT-1:0] dout_imag
);

   localparam int W2 = DATA_WIDTH_IN + 2;

   logic [2:0]                      r_pos;
   logic                            r_s1_valid;
   logic                            r_s1_last;
   logic [1:0]                      r_s1_k;
   logic signed [W2-1:0]            r_s1_re;
   logic signed [W2-1:0]            r_s1_im;
   logic                            r_out_valid;
   logic                            r_out_last;
   logic signed [DATA_WIDTH_OUT-1:0] r_out_re;
   logic signed [DATA_WIDTH_OUT-1:0] r_out_im;

   logic                 w_s2_load;
   logic [2:0]           w_p;
   logic [1:0]           w_k;
   logic signed [W2-1:0] w_a;
   logic signed [W2-1:0] w_b;
   logic signed [W2-1:0] w_rot_re;
   logic signed [W2-1:0] w_rot_im;
   logic signed [W2-1:0] w_sc_re;
   logic signed [W2-1:0] w_sc_im;
   logic                 w_odd_k;
   logic signed [W2-1:0] w_sel_re;
   logic signed [W2-1:0] w_sel_im;

   // valid/ready: a sample moves on a rising edge where valid && ready; the sender holds
   // data stable while valid && !ready. in_ready depends on out_ready, never on in_valid.
   assign w_s2_load = !r_out_valid || out_ready;
   assign in_ready  = !r_s1_valid || w_s2_load;

   assign w_p = in_sync ? 3'd0 : r_pos;
   assign w_k = tw8_index(w_p);
   assign w_a = {{2{din_real[DATA_WIDTH_IN-1]}}, din_real};
   assign w_b = {{2{din_imag[DATA_WIDTH_IN-1]}}, din_imag};

   // Multiply by (1+j)^k-style integer twiddles; the 45/135 degree cases still carry sqrt2.
   always_comb begin
      w_rot_re = w_a;
      w_rot_im = w_b;
      case (w_k)
         TW_45:  begin w_rot_re = w_a - w_b;  w_rot_im = w_a + w_b; end
         TW_90:  begin w_rot_re = -w_b;       w_rot_im = w_a;       end
         TW_135: begin w_rot_re = -w_a - w_b; w_rot_im = w_a - w_b; end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pos      <= '0;
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_k     <= TW_0;
         r_s1_re    <= '0;
         r_s1_im    <= '0;
      end else if (in_ready) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_pos     <= w_p + 3'd1;
            r_s1_last <= (w_p == 3'(BLOCK_SIZE - 1));
            r_s1_k    <= w_k;
            r_s1_re   <= w_rot_re;
            r_s1_im   <= w_rot_im;
         end
      end
   end

   rsqrt2_scale #(.WIDTH(W2)) u_scale_re (.i_x(r_s1_re), .o_y(w_sc_re));
   rsqrt2_scale #(.WIDTH(W2)) u_scale_im (.i_x(r_s1_im), .o_y(w_sc_im));

   assign w_odd_k  = (r_s1_k == TW_45) || (r_s1_k == TW_135);
   assign w_sel_re = w_odd_k ? w_sc_re : r_s1_re;
   assign w_sel_im = w_odd_k ? w_sc_im : r_s1_im;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_re    <= '0;
         r_out_im    <= '0;
      end else if (w_s2_load) begin
         r_out_valid <= r_s1_valid;
         r_out_last  <= r_s1_valid && r_s1_last;
         if (r_s1_valid) begin
            r_out_re <= DATA_WIDTH_OUT'(w_sel_re);
            r_out_im <= DATA_WIDTH_OUT'(w_sel_im);
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign dout_real = r_out_re;
   assign dout_imag = r_out_im;

endmodule

// File: tb/tb_twiddle8_conj_stream.sv
// Bench for twiddle8_conj_stream: directed and random streams against a complex-multiply model.
// Honours TWIDDLE8_CONJ_ROUND_EN for the expected 1/sqrt2 rounding.
module tb_twiddle8_conj_stream;

   localparam int WI = 10;
   localparam int WO = WI + 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_sync;
   logic signed [WI-1:0] din_real;
   logic signed [WI-1:0] din_imag;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_last;
   logic signed [WO-1:0] dout_real;
   logic signed [WO-1:0] dout_imag;

   logic [2*WO:0] exp_q[$];
   int errors = 0;
   int checks = 0;
   int accept_cnt = 0;
   int out_cnt = 0;
   int model_pos = 0;

   // W8^-k for k = 0..3 scaled by sqrt2 on the diagonals: 1, 1+j, j, -1+j
   int ktab[8]  = '{0, 0, 0, 0, 0, 2, 1, 3};
   int tw_re[4] = '{1, 1, 0, -1};
   int tw_im[4] = '{0, 1, 1, 1};

   always #5 clk = ~clk;

   twiddle8_conj_stream dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_sync(in_sync),
      .din_real(din_real), .din_imag(din_imag),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .dout_real(dout_real), .dout_imag(dout_imag)
   );

   task automatic chk(input string name, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   function automatic int fdiv(input int x, input int sh);
      int d;
      d = 1 << sh;
`ifdef TWIDDLE8_CONJ_ROUND_EN
      x = x + d / 2;
`endif
      if (x >= 0) return x / d;
      return -((-x + d - 1) / d);
   endfunction

   // 181/256 gain built from the 1/16, 1/4, 1/4 shift-add chain
   function automatic int gain(input int x);
      int t1, t2;
      t1 = x - fdiv(x, 4);
      t2 = t1 + fdiv(t1, 2);
      return x - fdiv(t2, 2);
   endfunction

   function automatic logic [2*WO:0] model(input int a, input int b, input int p);
      int k, re, im;
      k  = ktab[p];
      re = a * tw_re[k] - b * tw_im[k];
      im = a * tw_im[k] + b * tw_re[k];
      if (k % 2 == 1) begin
         re = gain(re);
         im = gain(im);
      end
      return {p == 7, WO'(re), WO'(im)};
   endfunction

   function automatic int rand_sample();
      int r;
      r = $urandom_range(0, 7);
      if (r == 0) return -512;
      if (r == 1) return 511;
      return $urandom_range(0, 1023) - 512;
   endfunction

   // Stimulus side of the scoreboard: every accepted sample pushes its expected output.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         model_pos = 0;
      end else if (in_valid && in_ready) begin
         int p;
         p = in_sync ? 0 : model_pos;
         exp_q.push_back(model(int'(din_real), int'(din_imag), p));
         model_pos = (p + 1) % 8;
         accept_cnt++;
      end
   end

   // Monitor: pops on every output handshake and checks stability while stalled.
   logic [2*WO:0] held;
   bit            held_v = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            checks++;
            if (!out_valid || {out_last, dout_real, dout_imag} !== held) begin
               errors++;
               $display("FAIL hold_stable: got valid=%0b re=%0d im=%0d last=%0b, expected held re=%0d im=%0d last=%0b",
                        out_valid, dout_real, dout_imag, out_last,
                        $signed(held[2*WO-1:WO]), $signed(held[WO-1:0]), held[2*WO]);
            end
         end
         held_v = 1'b0;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL out_unexpected: got re=%0d im=%0d with no sample expected", dout_real, dout_imag);
            end else begin
               logic [2*WO:0] e;
               e = exp_q.pop_front();
               if ({out_last, dout_real, dout_imag} !== e) begin
                  errors++;
                  $display("FAIL out[%0d]: got re=%0d im=%0d last=%0b, expected re=%0d im=%0d last=%0b",
                           out_cnt, dout_real, dout_imag, out_last,
                           $signed(e[2*WO-1:WO]), $signed(e[WO-1:0]), e[2*WO]);
               end
            end
            out_cnt++;
         end else if (out_valid) begin
            held   = {out_last, dout_real, dout_imag};
            held_v = 1'b1;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input int re, input int im, input bit sync);
      int n;
      n = 0;
      din_real = WI'(re);
      din_imag = WI'(im);
      in_sync  = sync;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sync  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      int base, n, target, cyc;
      rst = 1'b1; in_valid = 1'b0; in_sync = 1'b0;
      din_real = '0; din_imag = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_last", out_last, 0);
      chk("reset_dout_real", dout_real, 0);
      chk("reset_dout_imag", dout_imag, 0);
      chk("reset_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;

      // One block of (100,0): first sample also measures the two-cycle latency.
      send(100, 0, 1'b1);
      @(negedge clk);
      chk("latency_cycle1", out_valid, 0);
      @(negedge clk);
      chk("latency_cycle2", out_valid, 1);
      @(posedge clk); #1;
      for (int i = 1; i < 8; i++) send(100, 0, 1'b0);
      // Full-scale negative corner on every position.
      for (int i = 0; i < 8; i++) send(-512, -512, i == 0);
      drain();

      // Backpressure from an empty pipe: exactly two samples get queued.
      out_ready = 1'b0;
      base = accept_cnt;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_sync  = (i == 0);
         din_real = WI'(rand_sample());
         din_imag = WI'(rand_sample());
         @(posedge clk); #1;
      end
      chk("stall_accepts", accept_cnt - base, 2);
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) send(rand_sample(), rand_sample(), 1'b0);
      drain();

      // Re-sync on the third sample of a block, then a full block after it.
      send(rand_sample(), rand_sample(), 1'b1);
      send(rand_sample(), rand_sample(), 1'b0);
      send(300, -200, 1'b1);
      for (int i = 0; i < 8; i++) send(rand_sample(), rand_sample(), 1'b0);
      drain();

      // Reset with both stages full.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      din_real  = WI'(250);
      din_imag  = WI'(-100);
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         if (!in_ready) break;
         @(posedge clk); #1;
         n++;
      end
      chk("full_in_ready", in_ready, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midreset_out_valid", out_valid, 0);
      chk("midreset_out_last", out_last, 0);
      chk("midreset_dout_real", dout_real, 0);
      chk("midreset_in_ready", in_ready, 1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) send(rand_sample(), rand_sample(), 1'b0);
      drain();

      // Random valid/ready/sync traffic.
      target = accept_cnt + 4000;
      cyc = 0;
      while (accept_cnt < target && cyc < 40000) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_sync   = ($urandom_range(0, 15) == 0);
         din_real  = WI'(rand_sample());
         din_imag  = WI'(rand_sample());
         out_ready = ($urandom_range(0, 9) < 7);
         @(posedge clk); #1;
         cyc++;
      end
      chk("random_accepted", accept_cnt >= target, 1);
      in_sync = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, outputs seen %0d", out_cnt);
      $fatal(1, "watchdog");
   end

endmodule
